// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: one request in flight, word-addressed memory,
// read-modify-write for sub-word stores, lane-extracted and extended load results.
module mem_access_unit #(
  parameter int MEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_fault
);

  localparam logic [31:0] DEPTH_W = MEM_DEPTH;

  typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, DONE} state_t;
  state_t state, state_nx;

  logic        xfer, mem_op, fault;
  logic [31:0] widx;
  logic [1:0]  size_q, off_q;
  logic        uns_q, fault_q;
  logic [15:0] wdata_q;
  logic [31:0] addr_q, wword_q, data_q;
  logic [4:0]  rd_q;

  assign xfer   = in_valid && in_ready;
  assign mem_op = in_load || in_store;
  assign widx   = {2'b00, in_addr[31:2]};
  assign fault  = (in_load && in_store) ||
                  (mem_op && ((in_size == 2'b11) ||
                              (in_size == 2'b01 && in_addr[0]) ||
                              (in_size == 2'b10 && in_addr[1:0] != 2'b00) ||
                              (widx >= DEPTH_W)));

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (sz)
      2'b00:   extract = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = w;
    endcase
  endfunction

  // Replace only the addressed lane(s); the other bytes of the read word pass through.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                        input logic [1:0] sz, input logic [15:0] d);
    logic [31:0] mask, ins;
    mask = ((sz == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << {off, 3'b000};
    ins  = ((sz == 2'b00) ? {24'h0, d[7:0]} : {16'h0, d}) << {off, 3'b000};
    merge = (w & ~mask) | (ins & mask);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (fault || !mem_op)        state_nx = DONE;
          else if (in_load)            state_nx = READ;
          else if (in_size == 2'b10)   state_nx = WRITE;
          else                         state_nx = RMW_READ;
        end
      end
      READ: begin
        mem_re   = 1'b1;
        state_nx = DONE;
      end
      RMW_READ: begin
        mem_re   = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset overrides everything so a write in flight can never land.
    if (rst) begin
      in_ready  = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      wdata_q <= 16'h0;
      addr_q  <= 32'h0;
      wword_q <= 32'h0;
      data_q  <= 32'h0;
      rd_q    <= 5'h0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          size_q  <= in_size;
          off_q   <= in_addr[1:0];
          uns_q   <= in_unsigned;
          fault_q <= fault;
          wdata_q <= in_wdata[15:0];
          rd_q    <= in_rd;
          data_q  <= (fault || mem_op) ? 32'h0 : in_addr;
          if (!fault && mem_op) addr_q <= widx;
          if (!fault && in_store && in_size == 2'b10) wword_q <= in_wdata;
        end
        READ: begin
          data_q <= extract(mem_rdata, off_q, size_q, uns_q);
          addr_q <= 32'h0;
        end
        RMW_READ: wword_q <= merge(mem_rdata, off_q, size_q, wdata_q);
        WRITE: begin
          addr_q  <= 32'h0;
          wword_q <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wword_q;
  assign out_data  = data_q;
  assign out_rd    = rd_q;
  assign out_fault = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory model, queue scoreboard,
// directed scenarios followed by randomized traffic with random back-pressure.
module tb_mem_access_unit;

  localparam int MEM_DEPTH = 128;
  localparam int AW = $clog2(MEM_DEPTH);

  logic        clk, rst;
  logic        in_valid, in_ready, in_load, in_store, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        out_valid, out_ready, out_fault;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  mem_access_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_fault(out_fault)
  );

  // Environment memory (word array) that the DUT drives.
  logic [31:0] mem [MEM_DEPTH];
  assign mem_rdata = (mem_addr < MEM_DEPTH) ? mem[mem_addr[AW-1:0]] : 32'h0;
  always @(posedge clk) if (mem_we && mem_addr < MEM_DEPTH) mem[mem_addr[AW-1:0]] <= mem_wdata;

  // Reference model state: a flat byte array.
  logic [7:0] ref_bytes [4*MEM_DEPTH];

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
    int          lat;
    int          ts;
    int          we;
    int          re;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  int we_cnt = 0, re_cnt = 0;
  int rmode = 0;
  logic [31:0] cur_widx, cur_wword;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic ld, input logic st, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [4:0] rd);
    exp_t e;
    int n;
    logic [31:0] v;
    logic memop, bad;
    memop = ld || st;
    e.rd = rd; e.data = 0; e.fault = 0; e.we = 0; e.re = 0; e.lat = 1; e.ts = 0;
    bad = (ld && st) || (memop && (sz == 2'd3 || (sz == 2'd1 && a[0]) ||
          (sz == 2'd2 && a[1:0] != 2'd0) || (a >> 2) >= MEM_DEPTH));
    if (bad) e.fault = 1;
    else if (!memop) e.data = a;
    else begin
      n = 1 << sz;
      if (ld) begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
        if (n < 4 && !uns && ref_bytes[a + n - 1][7]) v = v | (32'hffff_ffff << (8 * n));
        e.data = v; e.lat = 2; e.re = 1;
      end else begin
        for (int i = 0; i < n; i++) ref_bytes[a + i] = wd[8*i +: 8];
        e.we = 1; e.re = (n < 4) ? 1 : 0; e.lat = (n < 4) ? 3 : 2;
      end
    end
    return e;
  endfunction

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    exp_t e;
    int n;
    int w;
    @(posedge clk); #1;
    in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
    in_addr = a; in_wdata = wd; in_rd = rd; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 60) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    if (in_ready) begin
      e = model(ld, st, sz, uns, a, wd, rd);
      e.ts = cyc;
      cur_widx = a >> 2;
      if (e.we == 1) begin
        w = 4 * int'(a >> 2);
        cur_wword = {ref_bytes[w+3], ref_bytes[w+2], ref_bytes[w+1], ref_bytes[w]};
      end
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && in_ready) break;
    end
    if (i == 200) chk("drain_timeout", 64'(q.size()), 0);
  endtask

  // Monitor / scoreboard
  logic        pv = 1'b0, pstall = 1'b0;
  logic [38:0] phold;
  always @(negedge clk) begin
    exp_t it;
    if (rst) begin
      q.delete(); we_cnt = 0; re_cnt = 0; pv = 1'b0; pstall = 1'b0;
    end else begin
      if (mem_we) we_cnt++;
      if (mem_re) re_cnt++;
      if (mem_we || mem_re) chk("mem_addr", mem_addr, cur_widx);
      if (mem_we) chk("mem_wdata", mem_wdata, cur_wword);
      if (pstall) chk("hold_stable", {out_valid, out_fault, out_rd, out_data}, {1'b1, phold[37:0]});
      if (out_valid) begin
        chk("valid_ready_excl", in_ready, 0);
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          if (!pv) chk("latency", 64'(cyc - q[0].ts), 64'(q[0].lat));
          if (out_ready) begin
            it = q.pop_front();
            chk("out_data", out_data, it.data);
            chk("out_rd", out_rd, it.rd);
            chk("out_fault", out_fault, it.fault);
            chk("we_pulses", 64'(we_cnt), 64'(it.we));
            chk("re_pulses", 64'(re_cnt), 64'(it.re));
            we_cnt = 0; re_cnt = 0;
          end
        end
      end
      pv = out_valid;
      pstall = out_valid && !out_ready;
      phold = {out_valid, out_fault, out_rd, out_data};
    end
  end

  initial begin
    logic [31:0] w, a;
    int kind;
    logic [1:0] sz;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w[8*k +: 8];
    end
    cur_widx = 0; cur_wword = 0;
    rst = 1'b1; in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd2;
    in_unsigned = 1'b0; in_addr = 32'h10; in_wdata = 32'h0; in_rd = 5'd3;

    // Reset held two cycles with a request pending
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outs", {out_valid, out_fault, out_rd, out_data}, 0);
    chk("rst_mem", {mem_we, mem_re, mem_addr, mem_wdata}, 0);
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Word store then load
    issue(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 5'd1);
    issue(1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd2);
    // Sub-word
    issue(0, 1, 2'd0, 0, 32'h11, 32'h55, 5'd3);
    wait_idle();
    chk("sb_merge_word4", mem[4], 32'hDEAD55EF);
    issue(1, 0, 2'd0, 0, 32'h13, 32'h0, 5'd4);
    issue(1, 0, 2'd0, 1, 32'h13, 32'h0, 5'd5);
    issue(1, 0, 2'd1, 0, 32'h12, 32'h0, 5'd6);
    // Faults and pass-through
    issue(1, 0, 2'd2, 0, 32'h12, 32'h0, 5'd7);
    issue(0, 1, 2'd1, 0, 32'h11, 32'h1234, 5'd8);
    issue(1, 0, 2'd2, 0, 32'h200, 32'h0, 5'd9);
    issue(1, 1, 2'd2, 0, 32'h10, 32'h0, 5'd10);
    issue(0, 0, 2'd3, 0, 32'hCAFE_F00D, 32'h0, 5'd11);
    wait_idle();

    // Back-pressure
    rmode = 2;
    issue(1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd12);
    repeat (6) @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    rmode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle", in_ready, 1);

    // Reset in the WRITE cycle of a sub-word store
    wait_idle();
    cur_widx = 32'd4;
    @(posedge clk); #1;
    in_load = 0; in_store = 1; in_size = 2'd0; in_unsigned = 0;
    in_addr = 32'h11; in_wdata = 32'hAA; in_rd = 5'd13; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rmw_read_re", mem_re, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_write_we", mem_we, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_write_word4", mem[4], 32'hDEAD55EF);
    chk("rst_write_idle", in_ready, 1);

    // Randomized traffic with random back-pressure
    rmode = 1;
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 9);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(512, 700)) : 32'($urandom_range(0, 511));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if (kind == 8) a = $urandom;
      issue(kind < 4 || kind == 9, (kind >= 4 && kind < 8) || kind == 9, sz,
            1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)));
    end
    rmode = 0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store controller sitting between the EX stage and the word-addressed data memory. It accepts one memory request at a time over a valid/ready handshake, converts the byte address into a word index, and sequences the memory's level-sensitive read and write enables. Sub-word stores are performed as read-modify-write. Load results are delivered lane-extracted and sign- or zero-extended on a valid/ready output toward writeback.

## Interface
- MEM_DEPTH, 128: number of 32-bit words in data memory; valid word index range is 0..MEM_DEPTH-1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- in_load  in  1  request is a load.
- in_store  in  1  request is a store.
- in_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- in_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- in_addr  in  32  byte address, also the ALU result for pass-through.
- in_wdata  in  32  store data, right-aligned.
- in_rd  in  5  destination register tag, carried to output.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_addr  out  32  word index, equal to request byte address >> 2.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  memory read data, combinational from mem_addr.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  load result, or pass-through ALU value.
- out_rd  out  5  tag of the completed request.
- out_fault  out  1  request was rejected without memory access.

## Operation
- States: IDLE, READ, RMW_READ, WRITE, DONE.
- in_ready = (state==IDLE). A transfer occurs when in_valid && in_ready. The request is registered on transfer.
- Little-endian byte lanes: offset = addr[1:0]; lane k = bits [8k+7:8k]. A halfword uses lanes {addr[1],0}.
- Fault checks are evaluated at transfer; any fault sends the unit IDLE->DONE with out_fault=1, out_data=0, and no memory access. Fault conditions:
  - in_load && in_store
  - in_size==11 on a memory op
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - (addr>>2) >= MEM_DEPTH
- Neither load nor store (pass-through): IDLE->DONE, out_data=in_addr, out_fault=0, no memory access.
- Load: IDLE->READ->DONE.
  - READ: mem_re=1; the selected lane(s) of mem_rdata are extended and registered into out_data at the end of the cycle.
- Word store: IDLE->WRITE->DONE.
  - WRITE: mem_we=1, mem_wdata=in_wdata.
  - out_data=0 for stores.
- Byte/half store: IDLE->RMW_READ->WRITE->DONE.
  - RMW_READ: mem_re=1; mem_rdata is registered with the target lane(s) replaced by in_wdata[7:0] or in_wdata[15:0].
  - WRITE: writes the merged word; the other lanes are unchanged.
- DONE: out_valid=1; out_data, out_rd and out_fault are held stable until out_ready, then the unit returns to IDLE.
- mem_we and mem_re are a Moore decode of state, gated by !rst. No memory access occurs in any cycle with rst=1.
- mem_addr and mem_wdata come from registers; both are 0 while IDLE or DONE.

## Timing
- Reset values: state=IDLE, in_ready=1 (after reset deasserts), out_valid=0, out_data=0, out_rd=0, out_fault=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- In cycles with rst=1, in_ready is 0.
- With the transfer at cycle T, the earliest out_valid is:
  - T+1 for pass-through or fault
  - T+2 for a load or a word store
  - T+3 for a byte/half store
- mem_we is high for exactly one cycle per store; mem_re is high for exactly one cycle per load or sub-word store.
- Throughput: one request in flight. The next transfer is possible in the cycle after the DONE handshake completes; out_valid and in_ready are never high together.
- Back-pressure: out_ready=0 holds the unit in DONE indefinitely, with outputs unchanged.
- Reset mid-operation, in any state: the next state is IDLE, the outstanding request is dropped, and no partial write occurs. In particular, rst=1 during WRITE suppresses mem_we.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → all outputs 0, no transfer. Release → in_ready=1.
- Word store then load: SW addr=0x10, data=0xDEADBEEF → one mem_we pulse, mem_addr=4. Then LW addr=0x10 → out_data=0xDEADBEEF at T+2.
- Sub-word: memory word 4 = 0xDEADBEEF.
  - SB addr=0x11, data=0x55 → word becomes 0xDEAD55EF.
  - LB addr=0x13 → 0xFFFFFFDE.
  - LBU addr=0x13 → 0x000000DE.
  - LH addr=0x12 → 0xFFFFDEAD.
- Faults, each with out_fault=1 at T+1 and mem_we/mem_re never asserted:
  - LW addr=0x12
  - SH addr=0x11
  - LW addr=0x200 (index 128)
  - in_load=in_store=1
- Back-pressure: LW with out_ready=0 for 5 cycles → out_valid held, data stable, in_ready=0. Pulse out_ready → IDLE the next cycle.
- Reset during RMW: assert rst in the WRITE cycle of SB addr=0x11 → mem_we stays 0 and the memory word is unchanged.
